// File: rtl/ntt_arbiter.sv
// ntt_arbiter: shares one ntt core between two coefficient-stream requesters.
// A grant covers a whole job: N input beats into the core, then N result beats
// routed back to the owner only. Arbitration is round-robin by default; define
// NTT_ARB_FIXED_PRIO_EN to make requester 0 always win when it is valid.
module ntt_arbiter #(
   parameter int unsigned q    = 17,
   parameter int unsigned N    = 8,
   parameter int unsigned logq = 5,
   parameter int unsigned logN = 3
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            req0_valid,
   input  logic [logq-1:0] req0_data,
   output logic            req0_ready,
   output logic            rsp0_valid,
   output logic [logq-1:0] rsp0_data,
   input  logic            rsp0_ready,
   output logic            rsp0_last,
   input  logic            req1_valid,
   input  logic [logq-1:0] req1_data,
   output logic            req1_ready,
   output logic            rsp1_valid,
   output logic [logq-1:0] rsp1_data,
   input  logic            rsp1_ready,
   output logic            rsp1_last,
   output logic            core_in_valid,
   output logic [logq-1:0] core_poly_in,
   input  logic            core_in_ready,
   input  logic            core_out_valid,
   input  logic [logq-1:0] core_poly_out,
   output logic            core_out_ready,
   output logic            busy,
   output logic            owner
);

   typedef enum logic [1:0] {IDLE, LOAD, UNLOAD} state_t;

   localparam logic [logN-1:0] CNT_LAST = logN'(N - 1);
   // Counter wrap relies on N == 2**logN; coefficients must fit below 2**logq.
   localparam bit CFG_OK = (N == (1 << logN)) && (q <= (1 << logq));

   // Empty marker block: a bad configuration shows up in the elaborated hierarchy.
   if (!CFG_OK) begin : g_bad_cfg
   end

   state_t          state;
   logic            last_grant;
   logic [logN-1:0] cnt;
   logic            winner;
   logic            any_req;
   logic            in_beat;
   logic            out_beat;

   assign any_req  = req0_valid | req1_valid;
   assign in_beat  = core_in_valid & core_in_ready;
   assign out_beat = core_out_valid & core_out_ready;

   // Pick the next owner among valid requesters.
   always_comb begin
      winner = 1'b0;
`ifdef NTT_ARB_FIXED_PRIO_EN
      winner = ~req0_valid;
`else
      if (req0_valid && req1_valid) begin
         winner = ~last_grant;
      end else begin
         winner = req1_valid;
      end
`endif
   end

   // Job-level FSM: grant, count input beats, count result beats, release.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= '0;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  owner      <= winner;
                  last_grant <= winner;
                  cnt        <= '0;
                  state      <= LOAD;
                  busy       <= 1'b1;
               end
            end
            LOAD: begin
               if (in_beat) begin
                  if (cnt == CNT_LAST) begin
                     cnt   <= '0;
                     state <= UNLOAD;
                  end else begin
                     cnt <= cnt + logN'(1);
                  end
               end
            end
            UNLOAD: begin
               if (out_beat) begin
                  if (cnt == CNT_LAST) begin
                     cnt   <= '0;
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     cnt <= cnt + logN'(1);
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Route the owner's streams to and from the core; everything else is held at 0.
   always_comb begin
      req0_ready     = 1'b0;
      req1_ready     = 1'b0;
      rsp0_valid     = 1'b0;
      rsp0_data      = '0;
      rsp0_last      = 1'b0;
      rsp1_valid     = 1'b0;
      rsp1_data      = '0;
      rsp1_last      = 1'b0;
      core_in_valid  = 1'b0;
      core_poly_in   = '0;
      core_out_ready = 1'b0;
      case (state)
         LOAD: begin
            if (owner) begin
               core_in_valid = req1_valid;
               core_poly_in  = req1_data;
               req1_ready    = core_in_ready;
            end else begin
               core_in_valid = req0_valid;
               core_poly_in  = req0_data;
               req0_ready    = core_in_ready;
            end
         end
         UNLOAD: begin
            if (owner) begin
               rsp1_valid     = core_out_valid;
               rsp1_data      = core_poly_out;
               rsp1_last      = core_out_valid & (cnt == CNT_LAST);
               core_out_ready = rsp1_ready;
            end else begin
               rsp0_valid     = core_out_valid;
               rsp0_data      = core_poly_out;
               rsp0_last      = core_out_valid & (cnt == CNT_LAST);
               core_out_ready = rsp0_ready;
            end
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_ntt_arbiter.sv
// tb_ntt_arbiter: directed bench for ntt_arbiter with a behavioural ntt core
// (cyclic NTT mod 17, root 2, results emitted in bit-reversed order).
module tb_ntt_arbiter;

   localparam int unsigned N    = 8;
   localparam int unsigned LOGQ = 5;

   typedef logic [LOGQ-1:0] vec_t [N];

   logic            clk = 1'b0;
   logic            reset_n;
   logic            req0_valid, req1_valid;
   logic [LOGQ-1:0] req0_data, req1_data;
   logic            req0_ready, req1_ready;
   logic            rsp0_valid, rsp1_valid;
   logic [LOGQ-1:0] rsp0_data, rsp1_data;
   logic            rsp0_ready, rsp1_ready;
   logic            rsp0_last, rsp1_last;
   logic            core_in_valid, core_in_ready;
   logic [LOGQ-1:0] core_poly_in, core_poly_out;
   logic            core_out_valid, core_out_ready;
   logic            busy, owner;

   int total = 0;
   int bad   = 0;

   ntt_arbiter #(.q(17), .N(8), .logq(5), .logN(3)) dut (
      .clk(clk), .reset_n(reset_n),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
      .rsp0_last(rsp0_last),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
      .rsp1_last(rsp1_last),
      .core_in_valid(core_in_valid), .core_poly_in(core_poly_in),
      .core_in_ready(core_in_ready), .core_out_valid(core_out_valid),
      .core_poly_out(core_poly_out), .core_out_ready(core_out_ready),
      .busy(busy), .owner(owner)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Reference transform: X[k] = sum x[j]*2^(jk) mod 17, output slot i holds X[bitrev(i)].
   function automatic vec_t ntt_br(input vec_t x);
      vec_t r;
      int   xk [N];
      for (int k = 0; k < int'(N); k++) begin
         int acc = 0;
         for (int j = 0; j < int'(N); j++) begin
            int w = 1;
            for (int t = 0; t < (j * k) % int'(N); t++) w = (w * 2) % 17;
            acc = (acc + int'(x[j]) * w) % 17;
         end
         xk[k] = acc;
      end
      for (int i = 0; i < int'(N); i++) begin
         int br = ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
         r[i] = LOGQ'(xk[br]);
      end
      return r;
   endfunction

   // Behavioural core: load N beats, compute for 3 cycles, stream N results.
   typedef enum logic [1:0] {C_LOAD, C_COMP, C_OUT} cst_t;
   cst_t cst;
   vec_t ibuf, obuf;
   int   ci, co, cdel;

   assign core_in_ready  = (cst == C_LOAD);
   assign core_out_valid = (cst == C_OUT);
   assign core_poly_out  = obuf[co];

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cst  <= C_LOAD;
         ci   <= 0;
         co   <= 0;
         cdel <= 0;
      end else begin
         case (cst)
            C_LOAD: if (core_in_valid && core_in_ready) begin
               ibuf[ci] <= core_poly_in;
               if (ci == int'(N) - 1) begin
                  ci   <= 0;
                  cdel <= 0;
                  cst  <= C_COMP;
               end else ci <= ci + 1;
            end
            C_COMP: begin
               cdel <= cdel + 1;
               if (cdel == 2) begin
                  obuf <= ntt_br(ibuf);
                  cst  <= C_OUT;
               end
            end
            default: if (core_out_ready) begin
               if (co == int'(N) - 1) begin
                  co  <= 0;
                  cst <= C_LOAD;
               end else co <= co + 1;
            end
         endcase
      end
   end

   // Monitor: capture result beats, grants and idle gaps on the falling edge.
   logic [LOGQ-1:0] r0_q [$];
   logic [LOGQ-1:0] r1_q [$];
   logic            l0_q [$];
   logic            l1_q [$];
   int              grant_q [$];
   int              gap_q [$];
   int              idle_run = 0;
   logic            prev_busy = 1'b0;
   int              rsp1_seen = 0;

   always @(negedge clk) begin
      if (rsp0_valid && rsp0_ready) begin
         r0_q.push_back(rsp0_data);
         l0_q.push_back(rsp0_last);
      end
      if (rsp1_valid && rsp1_ready) begin
         r1_q.push_back(rsp1_data);
         l1_q.push_back(rsp1_last);
      end
      if (rsp1_valid) rsp1_seen++;
      if (busy && !prev_busy) begin
         grant_q.push_back(int'(owner));
         gap_q.push_back(idle_run);
      end
      idle_run  = busy ? 0 : idle_run + 1;
      prev_busy = busy;
   end

   // Backpressure on requester 0 results: toggle ready every cycle while enabled.
   logic bp_en = 1'b0;
   always @(posedge clk) begin
      if (bp_en) #1 rsp0_ready = ~rsp0_ready;
   end

   task automatic clear_logs();
      r0_q.delete(); r1_q.delete(); l0_q.delete(); l1_q.delete();
      grant_q.delete(); gap_q.delete();
      rsp1_seen = 0;
   endtask

   task automatic set_req(input int who, input logic vl, input logic [LOGQ-1:0] d);
      if (who == 0) begin
         req0_valid = vl;
         req0_data  = d;
      end else begin
         req1_valid = vl;
         req1_data  = d;
      end
   endtask

   task automatic drive(input int who, input vec_t v);
      int   i = 0;
      int   budget = 0;
      logic rdy;
      set_req(who, 1'b1, v[0]);
      while (i < int'(N)) begin
         @(negedge clk);
         rdy = (who == 0) ? req0_ready : req1_ready;
         budget++;
         if (budget > 400) begin
            check($sformatf("drive%0d_timeout", who), 32'(i), 32'(N));
            set_req(who, 1'b0, '0);
            break;
         end
         if (rdy) begin
            @(posedge clk);
            #1;
            i++;
            if (i < int'(N)) set_req(who, 1'b1, v[i]);
            else set_req(who, 1'b0, '0);
         end
      end
   endtask

   task automatic wait_rsp(input int who, input int n);
      int budget = 0;
      while (((who == 0) ? r0_q.size() : r1_q.size()) < n && budget < 300) begin
         @(negedge clk);
         budget++;
      end
      check($sformatf("rsp%0d_count", who), 32'((who == 0) ? r0_q.size() : r1_q.size()), 32'(n));
   endtask

   task automatic check_job(input int who, input vec_t v, input int base);
      vec_t e = ntt_br(v);
      for (int i = 0; i < int'(N); i++) begin
         logic [LOGQ-1:0] d = (who == 0) ? r0_q[base + i] : r1_q[base + i];
         logic            l = (who == 0) ? l0_q[base + i] : l1_q[base + i];
         check($sformatf("rsp%0d_data[%0d]", who, base + i), 32'(d), 32'(e[i]));
         check($sformatf("rsp%0d_last[%0d]", who, base + i), 32'(l), 32'(i == int'(N) - 1));
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   vec_t va, vb, vc, vd, ve, exp1;
   int   beats;

   initial begin
      va   = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8};
      vb   = '{5'd3, 5'd1, 5'd4, 5'd1, 5'd5, 5'd9, 5'd2, 5'd6};
      vc   = '{5'd16, 5'd0, 5'd7, 5'd7, 5'd11, 5'd2, 5'd13, 5'd5};
      vd   = '{5'd8, 5'd8, 5'd1, 5'd0, 5'd0, 5'd15, 5'd4, 5'd10};
      ve   = '{5'd2, 5'd7, 5'd1, 5'd8, 5'd2, 5'd8, 5'd1, 5'd8};
      // NTT of 1..8 mod 17 (root 2), bit-reversed, worked by hand.
      exp1 = '{5'd2, 5'd13, 5'd14, 5'd12, 5'd8, 5'd3, 5'd6, 5'd1};

      reset_n    = 1'b0;
      req0_valid = 1'b0; req0_data = '0;
      req1_valid = 1'b0; req1_data = '0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;

      // Reset state
      #3;
      check("rst_busy", 32'(busy), 0);
      check("rst_owner", 32'(owner), 0);
      check("rst_core_in_valid", 32'(core_in_valid), 0);
      check("rst_core_out_ready", 32'(core_out_ready), 0);
      check("rst_req0_ready", 32'(req0_ready), 0);
      check("rst_rsp0_valid", 32'(rsp0_valid), 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Single job from requester 0, checked against hand-computed results
      clear_logs();
      drive(0, va);
      wait_rsp(0, 8);
      for (int i = 0; i < int'(N); i++) begin
         check($sformatf("single_data[%0d]", i), 32'(r0_q[i]), 32'(exp1[i]));
         check($sformatf("single_last[%0d]", i), 32'(l0_q[i]), 32'(i == int'(N) - 1));
      end
      check("single_rsp1_never", 32'(rsp1_seen), 0);
      check("single_grant", 32'(grant_q[0]), 0);
      repeat (2) @(negedge clk);

      // Simultaneous requests right after reset: 0 first, then 1, one idle cycle between
      do_reset();
      clear_logs();
      fork
         drive(0, vb);
         drive(1, vc);
      join
      wait_rsp(0, 8);
      wait_rsp(1, 8);
      check("sim_grants", 32'(grant_q.size()), 2);
      check("sim_grant0", 32'(grant_q[0]), 0);
      check("sim_grant1", 32'(grant_q[1]), 1);
      check("sim_gap", 32'(gap_q[1]), 1);
      check_job(0, vb, 0);
      check_job(1, vc, 0);
      repeat (2) @(negedge clk);

      // Continuous requests from both sides for four jobs
      clear_logs();
      fork
         begin drive(0, vd); drive(0, ve); end
         begin drive(1, va); drive(1, vb); end
      join
      wait_rsp(0, 16);
      wait_rsp(1, 16);
      check("cont_grants", 32'(grant_q.size()), 4);
`ifdef NTT_ARB_FIXED_PRIO_EN
      check("cont_grant0", 32'(grant_q[0]), 0);
      check("cont_grant1", 32'(grant_q[1]), 0);
      check("cont_grant2", 32'(grant_q[2]), 1);
      check("cont_grant3", 32'(grant_q[3]), 1);
`else
      check("cont_grant0", 32'(grant_q[0]), 0);
      check("cont_grant1", 32'(grant_q[1]), 1);
      check("cont_grant2", 32'(grant_q[2]), 0);
      check("cont_grant3", 32'(grant_q[3]), 1);
`endif
      for (int g = 1; g < 4; g++) check($sformatf("cont_gap%0d", g), 32'(gap_q[g]), 1);
      check_job(0, vd, 0);
      check_job(0, ve, 8);
      check_job(1, va, 0);
      check_job(1, vb, 8);
      repeat (2) @(negedge clk);

      // Backpressure on requester 0 results
      clear_logs();
      bp_en = 1'b1;
      drive(0, vc);
      wait_rsp(0, 8);
      bp_en = 1'b0;
      rsp0_ready = 1'b1;
      check_job(0, vc, 0);
      check("bp_rsp1_never", 32'(rsp1_seen), 0);
      repeat (3) @(negedge clk);
      check("bp_idle_after", 32'(busy), 0);

      // Reset in the middle of LOAD, then a fresh job
      clear_logs();
      beats = 0;
      set_req(0, 1'b1, vd[0]);
      for (int b = 0; b < 100 && beats < 3; b++) begin
         @(negedge clk);
         if (req0_ready) begin
            @(posedge clk);
            #1;
            beats++;
            req0_data = vd[beats];
         end
      end
      check("midrst_beats", 32'(beats), 3);
      #2;
      reset_n = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 0);
      check("midrst_req0_ready", 32'(req0_ready), 0);
      check("midrst_core_in_valid", 32'(core_in_valid), 0);
      check("midrst_owner", 32'(owner), 0);
      check("midrst_rsp0_valid", 32'(rsp0_valid), 0);
      set_req(0, 1'b0, '0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      clear_logs();
      drive(0, ve);
      wait_rsp(0, 8);
      check_job(0, ve, 0);
      check("midrst_grant", 32'(grant_q[0]), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/ntt_arbiter.md
# ntt_arbiter

Shares one `ntt` core between two independent coefficient-stream requesters. The arbiter grants the core to one requester for a whole transform job: N input beats, then N output beats. Response beats are routed back only to the owning requester. It sits between the two polynomial producers/consumers and a single `ntt` instance, and is clocked and reset with it.

## Interface
Parameters:
- `q`, 17, NTT modulus; passed through for consistency and not used in the arbiter's logic.
- `N`, 8, coefficients per job.
- `logq`, 5, coefficient width.
- `logN`, 3, log2(N); width of the beat counters.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `req0_valid` input 1: requester 0 input coefficient valid.
- `req0_data` input logq: requester 0 input coefficient.
- `req0_ready` output 1: requester 0 input accepted.
- `rsp0_valid` output 1: requester 0 result coefficient valid.
- `rsp0_data` output logq: requester 0 result coefficient.
- `rsp0_ready` input 1: requester 0 can take a result.
- `rsp0_last` output 1: marks the final (Nth) result beat.
- `req1_*` and `rsp1_*`: same set of ports as requester 0, for requester 1.
- `core_in_valid` output 1: connects to the core's `in_valid`.
- `core_poly_in` output logq: connects to the core's `poly_in`.
- `core_in_ready` input 1: connects to the core's `in_ready`.
- `core_out_valid` input 1: connects to the core's `out_valid`.
- `core_poly_out` input logq: connects to the core's `poly_out`.
- `core_out_ready` output 1: connects to the core's `out_ready`.
- `busy` output 1: high whenever the state is not IDLE.
- `owner` output 1: index of the current or last granted requester.

## Operation
- **States:** IDLE, LOAD, UNLOAD. Registers:
  - `state`
  - `owner`
  - `last_grant`
  - `cnt` (logN bits)
- **Reset values:**
  - state=IDLE, cnt=0, owner=0, last_grant=1.
  - All outputs are 0.
- **IDLE:**
  - All readies and valids are 0.
  - If any `reqX_valid` is high, pick a winner: owner←winner, last_grant←winner, cnt←0, state←LOAD.
  - Winner rule: if only one requester is valid, it wins. If both are valid, the one ≠ `last_grant` wins (round-robin).
- **LOAD:**
  - `core_in_valid`=`req[owner]_valid`, `core_poly_in`=`req[owner]_data`, `req[owner]_ready`=`core_in_ready`. The non-owner's ready stays 0.
  - A beat is a cycle with `core_in_valid`&`core_in_ready` high. Each beat increments cnt.
  - A beat at cnt=N-1 sets cnt←0 and state←UNLOAD.
- **UNLOAD:**
  - `rsp[owner]_valid`=`core_out_valid`, `rsp[owner]_data`=`core_poly_out`, `core_out_ready`=`rsp[owner]_ready`.
  - Non-owner rsp valid is 0. Non-owner `rsp_data` is driven 0.
  - `rsp[owner]_last`=`core_out_valid` & (cnt==N-1).
  - Each handshake increments cnt. The handshake at cnt=N-1 sets cnt←0 and state←IDLE.
  - While the core computes, `core_out_valid` is 0, so nothing transfers.
- **Lock:** a granted job is never pre-empted. Requests from the other requester wait in IDLE arbitration.
- **Counter:** cnt wraps in logN bits. N must equal 2^logN.

## Timing
- Grant latency: `reqX_valid` is sampled in IDLE at edge k, so the first input transfer can happen at edge k+1.
- Back-to-back jobs: after the final UNLOAD beat there is one IDLE cycle before the next grant.
- All datapath routing is combinational on registered `state`/`owner`. There is no added pipeline latency on data.
- Handshakes follow valid/ready rules: transfer on a rising edge with both high. A requester must hold valid and data stable until ready.
- `reqX_valid` dropping mid-LOAD stalls the job. It is not aborted.
- **Reset mid-operation:**
  - The arbiter returns to IDLE immediately (asynchronously), with the reset values above.
  - The core shares `reset_n` and must be reset together with the arbiter. A partial job is discarded.
- **Simultaneous events:**
  - A new request arriving on the final UNLOAD beat is arbitrated in the following IDLE cycle.
  - Both requesters valid in IDLE are resolved by `last_grant`.

## Configuration
- `NTT_ARB_FIXED_PRIO_EN` defined: fixed priority. Requester 0 always wins when valid. `last_grant` is still updated but ignored.
- Not defined (default): round-robin arbitration as described in Operation.

## Test plan
- **Single job:** req0 sends coefficients 1..8 with rsp0_ready=1. Required response:
  - exactly 8 rsp0 beats equal to the core's NTT of 1..8, in bit-reversed order;
  - rsp0_last only on beat 8;
  - rsp1_valid never high.
- **Simultaneous requests after reset:** req0 and req1 both valid. Required response:
  - req0's job is served first (last_grant reset value is 1), then req1;
  - owner reads 0, then 1;
  - busy is low for exactly one cycle between the jobs.
- **Continuous requests:** both requesters hold valid for 4 jobs. Grants alternate 0,1,0,1 (without the macro).
- **Backpressure:** rsp0_ready toggles 1,0,1,0 during UNLOAD. The 8 results arrive intact and in order, and cnt advances only on handshakes.
- **Reset mid-LOAD:** assert reset_n=0 after 3 input beats. Required response:
  - busy=0 and all readies/valids 0 immediately;
  - a fresh 8-beat job after release completes correctly.
- **`NTT_ARB_FIXED_PRIO_EN` defined:** both requesters held valid. req0 wins every arbitration and req1 is never granted.
